// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the 5-stage MIPS datapath and its hazard/forwarding controller.
// The datapath side uses the master modport; the controller uses the slave modport.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  // No valid/ready pairs: every field is level-valid in every cycle. The datapath presents
  // its pipeline-register fields and the controller answers combinationally in the same cycle.
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic              ex_memread;
  logic [REG_AW-1:0] ex_wreg;
  logic              mem_regwrite;
  logic [REG_AW-1:0] mem_wreg;
  logic              mem_memread;
  logic              mem_memwrite;
  logic              mem_pcsrc;
  logic              wb_regwrite;
  logic [REG_AW-1:0] wb_wreg;

  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              stall_pc;
  logic              stall_if_id;
  logic              bubble_id_ex;
  logic              freeze;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              flush_ex_mem;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_events;
  logic [1:0]        dbg_state;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_memread, ex_wreg,
           mem_regwrite, mem_wreg, mem_memread, mem_memwrite, mem_pcsrc,
           wb_regwrite, wb_wreg,
    input  fwd_a, fwd_b, stall_pc, stall_if_id, bubble_id_ex, freeze,
           flush_if_id, flush_id_ex, flush_ex_mem, stall_cycles, flush_events,
           dbg_state
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_memread, ex_wreg,
           mem_regwrite, mem_wreg, mem_memread, mem_memwrite, mem_pcsrc,
           wb_regwrite, wb_wreg,
    output fwd_a, fwd_b, stall_pc, stall_if_id, bubble_id_ex, freeze,
           flush_if_id, flush_id_ex, flush_ex_mem, stall_cycles, flush_events,
           dbg_state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Forwarding, load-use stall, branch flush and multi-cycle data-memory freeze control.
// Optional saturating performance counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam int                CW       = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0]     CNT_LOAD = CW'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            trig;
  logic            freeze_int;
  logic            branch;
  logic            lu;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic              m_rw,
    input logic [REG_AW-1:0] m_wreg,
    input logic              w_rw,
    input logic [REG_AW-1:0] w_wreg
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (m_rw && (m_wreg != REG_ZERO) && (m_wreg == src)) begin
      sel = 2'b10;
    end else if (w_rw && (w_wreg != REG_ZERO) && (w_wreg == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // The access sitting in MEM starts the wait only from RUN, so the MEM_DONE cycle
  // lets the served access leave MEM before the next one can trigger.
  always_comb begin
    trig    = (state_q == RUN) && (hz.mem_memread || hz.mem_memwrite) && (MEM_LAT > 1);
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (trig) begin
          cnt_d   = CNT_LOAD;
          state_d = (MEM_LAT == 2) ? MEM_DONE : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = MEM_DONE;
        end
      end
      MEM_DONE: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    freeze_int = trig || (state_q == MEM_WAIT);
    lu         = hz.ex_memread && (hz.ex_wreg != REG_ZERO) &&
                 ((hz.ex_wreg == hz.id_rs) || (hz.id_uses_rt && (hz.ex_wreg == hz.id_rt)));
    branch     = hz.mem_pcsrc && !freeze_int;

    hz.fwd_a        = 2'b00;
    hz.fwd_b        = 2'b00;
    hz.stall_pc     = 1'b0;
    hz.stall_if_id  = 1'b0;
    hz.bubble_id_ex = 1'b0;
    hz.freeze       = 1'b0;
    hz.flush_if_id  = 1'b0;
    hz.flush_id_ex  = 1'b0;
    hz.flush_ex_mem = 1'b0;
    hz.dbg_state    = 2'b00;

    if (!reset) begin
      hz.fwd_a        = fwd_sel(hz.ex_rs, hz.mem_regwrite, hz.mem_wreg, hz.wb_regwrite, hz.wb_wreg);
      hz.fwd_b        = fwd_sel(hz.ex_rt, hz.mem_regwrite, hz.mem_wreg, hz.wb_regwrite, hz.wb_wreg);
      hz.freeze       = freeze_int;
      // Freeze holds the front end itself; a taken branch discards the stalled instruction.
      hz.stall_pc     = freeze_int || (lu && !branch);
      hz.stall_if_id  = freeze_int || (lu && !branch);
      hz.bubble_id_ex = !freeze_int && !branch && lu;
      hz.flush_if_id  = branch;
      hz.flush_id_ex  = branch;
      hz.flush_ex_mem = branch;
      hz.dbg_state    = state_q;
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(1);

  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (hz.stall_pc && (stall_cycles_q != CNT_MAX)) begin
      stall_cycles_d = stall_cycles_q + CNT_STEP;
    end
    if (hz.flush_if_id && (flush_events_q != CNT_MAX)) begin
      flush_events_d = flush_events_q + CNT_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign hz.stall_cycles = reset ? {CNT_W{1'b0}} : stall_cycles_q;
  assign hz.flush_events = reset ? {CNT_W{1'b0}} : flush_events_q;
`else
  assign hz.stall_cycles = {CNT_W{1'b0}};
  assign hz.flush_events = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three instances (MEM_LAT 1, 4, 5) share one stimulus stream
// and are checked against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 2;
  localparam int N_DUT  = 3;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [REG_AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
  logic id_uses_rt, ex_memread, mem_regwrite, mem_memread, mem_memwrite, mem_pcsrc, wb_regwrite;

  // ctl = {stall_pc, stall_if_id, bubble_id_ex, freeze, flush_if_id, flush_id_ex, flush_ex_mem}
  logic [6:0]         o_ctl[N_DUT];
  logic [3:0]         o_fwd[N_DUT];
  logic [2*CNT_W-1:0] o_cnt[N_DUT];
  logic [6:0]         e_ctl[N_DUT];
  logic [3:0]         e_fwd[N_DUT];
  logic [2*CNT_W-1:0] e_cnt[N_DUT];

  int m_left[N_DUT];
  bit m_done[N_DUT];
  int m_sc[N_DUT];
  int m_fe[N_DUT];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 4 : 5);
    pipeline_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();
    assign hz.id_rs        = id_rs;
    assign hz.id_rt        = id_rt;
    assign hz.id_uses_rt   = id_uses_rt;
    assign hz.ex_rs        = ex_rs;
    assign hz.ex_rt        = ex_rt;
    assign hz.ex_memread   = ex_memread;
    assign hz.ex_wreg      = ex_wreg;
    assign hz.mem_regwrite = mem_regwrite;
    assign hz.mem_wreg     = mem_wreg;
    assign hz.mem_memread  = mem_memread;
    assign hz.mem_memwrite = mem_memwrite;
    assign hz.mem_pcsrc    = mem_pcsrc;
    assign hz.wb_regwrite  = wb_regwrite;
    assign hz.wb_wreg      = wb_wreg;

    pipeline_hazard_ctrl #(.REG_AW(REG_AW), .MEM_LAT(LAT), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
    );

    assign o_ctl[g] = {hz.stall_pc, hz.stall_if_id, hz.bubble_id_ex, hz.freeze,
                       hz.flush_if_id, hz.flush_id_ex, hz.flush_ex_mem};
    assign o_fwd[g] = {hz.fwd_a, hz.fwd_b};
    assign o_cnt[g] = {hz.stall_cycles, hz.flush_events};
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 5);
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [REG_AW-1:0] s);
    if (mem_regwrite && mem_wreg != 0 && mem_wreg == s) return 2'b10;
    if (wb_regwrite && wb_wreg != 0 && wb_wreg == s) return 2'b01;
    return 2'b00;
  endfunction

  // Expected outputs for the current cycle, from the model's access bookkeeping.
  task automatic compute_expected();
    logic lu, fz, br;
    lu = ex_memread && ex_wreg != 0 && (ex_wreg == id_rs || (id_uses_rt && ex_wreg == id_rt));
    for (int i = 0; i < N_DUT; i++) begin
      fz = (m_left[i] > 0) || (!m_done[i] && (mem_memread || mem_memwrite) && lat_of(i) > 1);
      br = mem_pcsrc && !fz;
      if (reset) begin
        e_ctl[i] = '0;
        e_fwd[i] = '0;
        e_cnt[i] = '0;
      end else begin
        e_ctl[i] = {fz || (lu && !br), fz || (lu && !br), !fz && !br && lu, fz, br, br, br};
        e_fwd[i] = {fwd_ref(ex_rs), fwd_ref(ex_rt)};
`ifdef HAZARD_PERF_EN
        e_cnt[i] = {CNT_W'(m_sc[i]), CNT_W'(m_fe[i])};
`else
        e_cnt[i] = '0;
`endif
      end
    end
  endtask

  // m_left counts frozen cycles still owed after the current one; m_done marks the release cycle.
  task automatic advance_model();
    for (int i = 0; i < N_DUT; i++) begin
      if (reset) begin
        m_left[i] = 0;
        m_done[i] = 1'b0;
        m_sc[i]   = 0;
        m_fe[i]   = 0;
      end else begin
        if (e_ctl[i][6] && m_sc[i] < CNT_SAT) m_sc[i]++;
        if (e_ctl[i][2] && m_fe[i] < CNT_SAT) m_fe[i]++;
        if (m_left[i] > 0) begin
          m_left[i]--;
          m_done[i] = (m_left[i] == 0);
        end else if (m_done[i]) begin
          m_done[i] = 1'b0;
        end else if ((mem_memread || mem_memwrite) && lat_of(i) > 1) begin
          m_left[i] = lat_of(i) - 2;
          m_done[i] = (lat_of(i) == 2);
        end
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    compute_expected();
  endtask

  task automatic advance();
    advance_model();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    ex_rs = '0; ex_rt = '0; ex_memread = 1'b0; ex_wreg = '0;
    mem_regwrite = 1'b0; mem_wreg = '0; mem_memread = 1'b0; mem_memwrite = 1'b0;
    mem_pcsrc = 1'b0; wb_regwrite = 1'b0; wb_wreg = '0;
  endtask

  task automatic randomize_inputs();
    id_rs = REG_AW'($urandom_range(0, 3)); id_rt = REG_AW'($urandom_range(0, 3));
    ex_rs = REG_AW'($urandom_range(0, 3)); ex_rt = REG_AW'($urandom_range(0, 3));
    ex_wreg = REG_AW'($urandom_range(0, 3)); mem_wreg = REG_AW'($urandom_range(0, 3));
    wb_wreg = REG_AW'($urandom_range(0, 3));
    id_uses_rt   = ($urandom_range(0, 1) == 1);
    ex_memread   = ($urandom_range(0, 9) < 3);
    mem_regwrite = ($urandom_range(0, 1) == 1);
    wb_regwrite  = ($urandom_range(0, 1) == 1);
    mem_memread  = ($urandom_range(0, 19) < 3);
    mem_memwrite = ($urandom_range(0, 19) < 2);
    mem_pcsrc    = ($urandom_range(0, 19) < 3);
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) begin
      settle();
      advance();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      randomize_inputs();
      mem_pcsrc = 1'b1; ex_memread = 1'b1; mem_memread = 1'b1;
      settle();
      for (int i = 0; i < N_DUT; i++) begin
        checks++;
        if (o_ctl[i] !== 7'b0 || o_fwd[i] !== 4'b0 || o_cnt[i] !== '0) begin
          errors++;
          $display("FAIL reset_outputs inst%0d: got ctl=%b fwd=%b cnt=%b expected all zero",
                   i, o_ctl[i], o_fwd[i], o_cnt[i]);
        end
      end
      advance();
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_forwarding();
    logic [1:0] want[4];
    want = '{2'b10, 2'b01, 2'b00, 2'b00};
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin ex_rs = 5'd3; mem_regwrite = 1'b1; mem_wreg = 5'd3; wb_regwrite = 1'b1; wb_wreg = 5'd3; end
        1: mem_regwrite = 1'b0;
        2: begin ex_rs = 5'd0; mem_wreg = 5'd0; mem_regwrite = 1'b1; end
        default: begin ex_rs = 5'd0; wb_wreg = 5'd0; wb_regwrite = 1'b1; end
      endcase
      settle();
      checks++;
      if (o_fwd[0][3:2] !== want[k]) begin
        errors++;
        $display("FAIL fwd_a step%0d: got %b expected %b", k, o_fwd[0][3:2], want[k]);
      end
      advance();
    end
    clear_inputs();
    ex_rt = 5'd6; mem_regwrite = 1'b1; mem_wreg = 5'd6; wb_regwrite = 1'b1; wb_wreg = 5'd6;
    settle();
    checks++;
    if (o_fwd[0][1:0] !== 2'b10) begin
      errors++;
      $display("FAIL fwd_b_mem_priority: got %b expected 10", o_fwd[0][1:0]);
    end
    advance();
    mem_wreg = 5'd7;
    settle();
    checks++;
    if (o_fwd[0][1:0] !== 2'b01) begin
      errors++;
      $display("FAIL fwd_b_wb: got %b expected 01", o_fwd[0][1:0]);
    end
    advance();
  endtask

  task automatic test_load_use();
    logic [6:0] want[5];
    want = '{7'b1110000, 7'b0000000, 7'b0000000, 7'b1110000, 7'b0000000};
    clear_inputs();
    for (int k = 0; k < 5; k++) begin
      clear_inputs();
      case (k)
        0: begin ex_memread = 1'b1; ex_wreg = 5'd2; id_rs = 5'd2; end
        1: begin id_rs = 5'd2; end
        2: begin ex_memread = 1'b1; ex_wreg = 5'd2; id_rs = 5'd7; id_rt = 5'd2; id_uses_rt = 1'b0; end
        3: begin ex_memread = 1'b1; ex_wreg = 5'd2; id_rs = 5'd7; id_rt = 5'd2; id_uses_rt = 1'b1; end
        default: begin ex_memread = 1'b1; ex_wreg = 5'd0; id_rs = 5'd0; end
      endcase
      settle();
      checks++;
      if (o_ctl[0] !== want[k]) begin
        errors++;
        $display("FAIL load_use step%0d: got %b expected %b", k, o_ctl[0], want[k]);
      end
      advance();
    end
  endtask

  task automatic test_mem_wait();
    idle(6);
    mem_memread = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++;
      if (o_ctl[1][6:3] !== ((k < 3) ? 4'b1101 : 4'b0000)) begin
        errors++;
        $display("FAIL mem_wait_lat4 cycle%0d: got %b expected %b", k, o_ctl[1][6:3],
                 (k < 3) ? 4'b1101 : 4'b0000);
      end
      checks++;
      if (o_ctl[0][3] !== 1'b0) begin
        errors++;
        $display("FAIL mem_wait_lat1 cycle%0d: got freeze=%b expected 0", k, o_ctl[0][3]);
      end
      checks++;
      if (o_ctl[2] !== e_ctl[2]) begin
        errors++;
        $display("FAIL mem_wait_lat5 cycle%0d: got %b expected %b", k, o_ctl[2], e_ctl[2]);
      end
      advance();
    end
    clear_inputs();
    for (int k = 0; k < 6; k++) begin
      settle();
      for (int i = 0; i < N_DUT; i++) begin
        checks++;
        if (o_ctl[i] !== e_ctl[i]) begin
          errors++;
          $display("FAIL mem_wait_drain inst%0d: got %b expected %b", i, o_ctl[i], e_ctl[i]);
        end
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    idle(6);
    mem_memwrite = 1'b1;
    for (int k = 0; k < 8; k++) begin
      settle();
      checks++;
      if (o_ctl[1][3] !== ((k % 4) != 3)) begin
        errors++;
        $display("FAIL back_to_back cycle%0d: got freeze=%b expected %b", k, o_ctl[1][3], (k % 4) != 3);
      end
      advance();
    end
    idle(6);
  endtask

  task automatic test_branch();
    idle(6);
    mem_pcsrc = 1'b1; ex_memread = 1'b1; ex_wreg = 5'd4; id_rs = 5'd4;
    settle();
    checks++;
    if (o_ctl[0] !== 7'b0000111) begin
      errors++;
      $display("FAIL branch_over_load_use: got %b expected 0000111", o_ctl[0]);
    end
    advance();
    clear_inputs();
    mem_pcsrc = 1'b1; mem_memread = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++;
      if (o_ctl[1] !== ((k < 3) ? 7'b1101000 : 7'b0000111)) begin
        errors++;
        $display("FAIL branch_deferred cycle%0d: got %b expected %b", k, o_ctl[1],
                 (k < 3) ? 7'b1101000 : 7'b0000111);
      end
      advance();
    end
    idle(6);
  endtask

  task automatic test_reset_mid();
    idle(6);
    mem_memread = 1'b1;
    settle(); advance();
    settle(); advance();
    reset = 1'b1;
    mem_pcsrc = 1'b1; ex_rs = 5'd1; mem_regwrite = 1'b1; mem_wreg = 5'd1;
    settle();
    for (int i = 0; i < N_DUT; i++) begin
      checks++;
      if (o_ctl[i] !== 7'b0 || o_fwd[i] !== 4'b0 || o_cnt[i] !== '0) begin
        errors++;
        $display("FAIL reset_mid inst%0d: got ctl=%b fwd=%b cnt=%b expected all zero",
                 i, o_ctl[i], o_fwd[i], o_cnt[i]);
      end
    end
    advance();
    reset = 1'b0;
    clear_inputs();
    for (int k = 0; k < 5; k++) begin
      settle();
      checks++;
      if (o_ctl[2][3] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_resume cycle%0d: got freeze=%b expected 0", k, o_ctl[2][3]);
      end
      advance();
    end
  endtask

  task automatic test_perf();
    int want_sc, want_fe;
    clear_inputs();
    reset = 1'b1;
    settle(); advance();
    reset = 1'b0;
    ex_memread = 1'b1; ex_wreg = 5'd2; id_rs = 5'd2;
    repeat (5) begin settle(); advance(); end
    clear_inputs();
    mem_pcsrc = 1'b1;
    settle(); advance();
    clear_inputs();
    settle();
`ifdef HAZARD_PERF_EN
    want_sc = 3; want_fe = 1;
`else
    want_sc = 0; want_fe = 0;
`endif
    for (int i = 0; i < N_DUT; i++) begin
      checks++;
      if (o_cnt[i] !== {CNT_W'(want_sc), CNT_W'(want_fe)}) begin
        errors++;
        $display("FAIL perf_counters inst%0d: got %b expected %b", i, o_cnt[i],
                 {CNT_W'(want_sc), CNT_W'(want_fe)});
      end
    end
    advance();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      randomize_inputs();
      reset = ($urandom_range(0, 49) == 0);
      settle();
      for (int i = 0; i < N_DUT; i++) begin
        checks++;
        if (o_ctl[i] !== e_ctl[i]) begin
          errors++;
          $display("FAIL rand_ctl cyc%0d inst%0d: got %b expected %b", k, i, o_ctl[i], e_ctl[i]);
        end
        checks++;
        if (o_fwd[i] !== e_fwd[i]) begin
          errors++;
          $display("FAIL rand_fwd cyc%0d inst%0d: got %b expected %b", k, i, o_fwd[i], e_fwd[i]);
        end
        checks++;
        if (o_cnt[i] !== e_cnt[i]) begin
          errors++;
          $display("FAIL rand_cnt cyc%0d inst%0d: got %b expected %b", k, i, o_cnt[i], e_cnt[i]);
        end
      end
      advance();
    end
    reset = 1'b0;
    idle(6);
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    for (int i = 0; i < N_DUT; i++) begin
      m_left[i] = 0; m_done[i] = 1'b0; m_sc[i] = 0; m_fe[i] = 0;
      e_ctl[i] = '0; e_fwd[i] = '0; e_cnt[i] = '0;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_wait();
    test_back_to_back();
    test_branch();
    test_reset_mid();
    test_perf();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
